mem_port_arbiter: RTL and testbench

- Arbitrates the single-ported unified instruction/data memory between the fetch stage (IF) and the load/store stage (MEM) of the pipelined RISC-V core.
- Grants at most one access per cycle and drives the memory port.
- Registers read data and returns it with a valid strobe one cycle after the grant.
- Raises stall to the losing requester and bounds fetch starvation with a data-streak counter.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-ported unified instruction/data memory between the fetch
// stage (IF) and the load/store stage (MEM). At most one access is granted per
// cycle. The grant and the memory-port drive are combinational, so a request
// is served in the cycle it is raised. Read data is captured at the edge that
// ends the grant and is returned with a one-cycle valid strobe. Data wins
// conflicts, but a streak counter hands the port to a waiting fetch after
// MAX_DATA_STREAK consecutive data grants.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   if_req/if_addr      fetch request and PC; held until if_ready
//   if_ready/if_stall   fetch granted this cycle / fetch waiting
//   if_rvalid/if_rdata  instruction word, valid the cycle after the grant
//   d_req/d_we/d_fn3/d_addr/d_wdata   load/store request; held until d_ready
//   d_ready/d_stall     data granted this cycle / data waiting
//   d_rvalid/d_rdata    load result, valid the cycle after a load grant
//   mem_*               memory port drive; mem_data_out is the combinational
//                       read data returned by the memory
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int          ADDR_W          = 11,
  parameter int          DATA_W          = 32,
  parameter int          MAX_DATA_STREAK = 2,
  parameter logic [2:0]  F3_LW           = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_fn3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_fn3,
  output logic [ADDR_W-1:0] mem_addrs,
  output logic              mem_is_fetch,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  owner_e               owner_d;
  owner_e               owner_q;
  logic [STREAK_W-1:0]  streak_q;
  logic                 load_q;     // the DATA grant recorded in owner_q was a load
  logic [DATA_W-1:0]    if_rdata_q;
  logic [DATA_W-1:0]    d_rdata_q;

  // Next owner. Reset suppresses every grant in its own cycle.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    owner_d = OWN_IDLE;
    if (rst) begin
      owner_d = OWN_IDLE;
    end else if (if_req && d_req) begin
      // Data has priority until the streak bound is reached.
      owner_d = (streak_q >= STREAK_MAX) ? OWN_FETCH : OWN_DATA;
    end else if (if_req) begin
      owner_d = OWN_FETCH;
    end else if (d_req) begin
      owner_d = OWN_DATA;
    end
  end

  // Memory-port drive and grants for the current owner.
  always_comb begin
    if_ready     = 1'b0;
    d_ready      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_fn3      = 3'b000;
    mem_addrs    = '0;
    mem_is_fetch = 1'b0;
    mem_data_in  = '0;
    case (owner_d)
      OWN_FETCH: begin
        if_ready     = 1'b1;
        mem_read     = 1'b1;
        mem_fn3      = F3_LW;
        mem_addrs    = if_addr;
        mem_is_fetch = 1'b1;
      end
      OWN_DATA: begin
        d_ready     = 1'b1;
        mem_read    = ~d_we;
        mem_write   = d_we;
        mem_fn3     = d_fn3;
        mem_addrs   = d_addr;
        mem_data_in = d_we ? d_wdata : '0;
      end
      default: ;
    endcase
  end

  // Owner register, streak counter and read-data capture.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff samples the pre-edge values regardless of evaluation order.
    if (rst) begin
      // NOTE: reset is synchronous here; the read-data registers are cleared
      // too, since their reset value is visible on if_rdata/d_rdata.
      owner_q    <= OWN_IDLE;
      streak_q   <= '0;
      load_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q <= owner_d;
      load_q  <= (owner_d == OWN_DATA) && !d_we;

      // A fetch grant or any cycle without a waiting fetch ends the streak.
      if (!if_req || owner_d == OWN_FETCH) begin
        streak_q <= '0;
      end else if (owner_d == OWN_DATA && streak_q < STREAK_MAX) begin
        streak_q <= streak_q + STREAK_W'(1);
      end

      if (owner_d == OWN_FETCH) begin
        if_rdata_q <= mem_data_out;
      end
      if (owner_d == OWN_DATA && !d_we) begin
        d_rdata_q <= mem_data_out;
      end
    end
  end

  // Responses come from the recorded owner; a reset cycle drops a pending
  // strobe and keeps the stall outputs quiet.
  assign if_rvalid = ~rst & (owner_q == OWN_FETCH);
  assign d_rvalid  = ~rst & (owner_q == OWN_DATA) & load_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = ~rst & if_req & ~if_ready;
  assign d_stall   = ~rst & d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives mem_port_arbiter with directed scenarios followed by randomized
// fetch/load/store traffic. A byte-array memory attached to the port responds
// to the DUT; a separate reference memory and a priority/streak model predict
// every grant, port drive and read response. Expected responses go into
// queues that an independent monitor drains whenever an rvalid strobe appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW   = 11;
  localparam int DW   = 32;
  localparam int MAXS = 2;
  localparam int MEM_BYTES = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready, if_stall, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [2:0]    d_fn3;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready, d_stall, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_read, mem_write, mem_is_fetch;
  logic [2:0]    mem_fn3;
  logic [AW-1:0] mem_addrs;
  logic [DW-1:0] mem_data_in, mem_data_out;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS), .F3_LW(3'b010)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_stall(if_stall), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_fn3(d_fn3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_stall(d_stall),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_fn3(mem_fn3),
    .mem_addrs(mem_addrs), .mem_is_fetch(mem_is_fetch),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Load extension rules; fn3 values outside the RISC-V load set return the
  // raw word.
  function automatic logic [31:0] extend(input logic [2:0] fn3, input logic [31:0] w,
                                         input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (fn3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- memory attached to the DUT port ----------------
  logic [7:0]    phys [MEM_BYTES];
  logic [AW-1:0] pa;
  logic [31:0]   pw;

  always_comb begin
    pa = {mem_addrs[AW-1:2], 2'b00};
    pw = {phys[pa + 11'd3], phys[pa + 11'd2], phys[pa + 11'd1], phys[pa]};
    mem_data_out = mem_read ? extend(mem_fn3, pw, mem_addrs[1:0]) : 32'h0;
  end

  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_fn3[1:0])
        2'b00: phys[mem_addrs] <= mem_data_in[7:0];
        2'b01: begin
          phys[mem_addrs]         <= mem_data_in[7:0];
          phys[mem_addrs + 11'd1] <= mem_data_in[15:8];
        end
        default: begin
          phys[pa]         <= mem_data_in[7:0];
          phys[pa + 11'd1] <= mem_data_in[15:8];
          phys[pa + 11'd2] <= mem_data_in[23:16];
          phys[pa + 11'd3] <= mem_data_in[31:24];
        end
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] refm [MEM_BYTES];
  int streak = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t if_q[$];
  exp_t d_q[$];

  function automatic logic [31:0] ref_load(input logic [2:0] fn3, input logic [AW-1:0] a);
    int base;
    logic [31:0] w;
    base = int'(a) & ~3;
    w = {refm[base + 3], refm[base + 2], refm[base + 1], refm[base]};
    return extend(fn3, w, a[1:0]);
  endfunction

  task automatic ref_store(input logic [2:0] fn3, input logic [AW-1:0] a, input logic [31:0] wd);
    int nbytes;
    int base;
    nbytes = (fn3[1:0] == 2'b00) ? 1 : (fn3[1:0] == 2'b01) ? 2 : 4;
    base = (nbytes == 4) ? (int'(a) & ~3) : int'(a);
    for (int i = 0; i < nbytes; i++) refm[base + i] = wd[8*i +: 8];
  endtask

  // One clock cycle: drive at posedge+1, check the combinational drive at the
  // negedge, then advance the model. g: 0 = no grant, 1 = fetch, 2 = data.
  // obs returns the DUT's {if_ready, d_ready} as seen at the negedge.
  task automatic do_cycle(input bit r, input bit ir, input logic [AW-1:0] ia,
                          input bit dr, input bit we, input logic [2:0] f3,
                          input logic [AW-1:0] da, input logic [31:0] wd,
                          output int g, output logic [1:0] obs);
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = we; d_fn3 = f3; d_addr = da; d_wdata = wd;

    if (r)             g = 0;
    else if (ir && dr) g = (streak >= MAXS) ? 1 : 2;
    else if (ir)       g = 1;
    else if (dr)       g = 2;
    else               g = 0;

    if (r) begin
      if_q.delete();
      d_q.delete();
    end

    @(negedge clk);
    obs = {if_ready, d_ready};
    check("if_ready", 32'(if_ready), 32'(g == 1));
    check("d_ready", 32'(d_ready), 32'(g == 2));
    check("if_stall", 32'(if_stall), 32'(!r && ir && g != 1));
    check("d_stall", 32'(d_stall), 32'(!r && dr && g != 2));
    check("mem_read", 32'(mem_read), 32'(g == 1 || (g == 2 && !we)));
    check("mem_write", 32'(mem_write), 32'(g == 2 && we));
    check("mem_is_fetch", 32'(mem_is_fetch), 32'(g == 1));
    case (g)
      1: begin
        check("mem_addrs_fetch", 32'(mem_addrs), 32'(ia));
        check("mem_fn3_fetch", 32'(mem_fn3), 32'd2);
        check("mem_data_in_fetch", mem_data_in, 32'h0);
        if_q.push_back('{due: cyc + 1, data: ref_load(3'b010, ia)});
      end
      2: begin
        check("mem_addrs_data", 32'(mem_addrs), 32'(da));
        check("mem_fn3_data", 32'(mem_fn3), 32'(f3));
        if (we) begin
          check("mem_data_in_store", mem_data_in, wd);
          ref_store(f3, da, wd);
        end else begin
          d_q.push_back('{due: cyc + 1, data: ref_load(f3, da)});
        end
      end
      default: begin
        check("mem_addrs_idle", 32'(mem_addrs), 32'h0);
        check("mem_fn3_idle", 32'(mem_fn3), 32'h0);
        check("mem_data_in_idle", mem_data_in, 32'h0);
      end
    endcase

    if (r || !ir || g == 1) streak = 0;
    else if (g == 2)        streak = (streak < MAXS) ? streak + 1 : MAXS;

    @(posedge clk);
    #1;
  endtask

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (if_q.size() == 0 || if_q[0].due != cyc) begin
        check("if_rvalid_unexpected", 32'(if_rvalid), 32'h0);
      end else begin
        check("if_rdata", if_rdata, if_q[0].data);
        void'(if_q.pop_front());
      end
    end else if (if_q.size() != 0 && if_q[0].due == cyc) begin
      check("if_rvalid_missing", 32'(if_rvalid), 32'h1);
      void'(if_q.pop_front());
    end

    if (d_rvalid) begin
      if (d_q.size() == 0 || d_q[0].due != cyc) begin
        check("d_rvalid_unexpected", 32'(d_rvalid), 32'h0);
      end else begin
        check("d_rdata", d_rdata, d_q[0].data);
        void'(d_q.pop_front());
      end
    end else if (d_q.size() != 0 && d_q[0].due == cyc) begin
      check("d_rvalid_missing", 32'(d_rvalid), 32'h1);
      void'(d_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  int         g;
  logic [1:0] obs;
  logic [1:0] conflict_want [6];
  logic [1:0] gap_want [5];
  bit         gap_if [5];

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      phys[i] = 8'($urandom);
      refm[i] = phys[i];
    end
    // Instruction word at 0x004 and a negative byte at 0x000.
    {phys[7], phys[6], phys[5], phys[4]} = 32'h0000_2083;
    {refm[7], refm[6], refm[5], refm[4]} = 32'h0000_2083;
    phys[0] = 8'hF3;
    refm[0] = 8'hF3;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_fn3 = 3'b000; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    #1;

    // Reset with a pending load request: nothing is granted.
    do_cycle(1, 0, 11'h000, 1, 0, 3'b010, 11'h010, 32'h0, g, obs);
    check("reset_d_rvalid", 32'(d_rvalid), 32'h0);
    check("reset_d_rdata", d_rdata, 32'h0);
    check("reset_if_rvalid", 32'(if_rvalid), 32'h0);
    check("reset_if_rdata", if_rdata, 32'h0);

    // Fetch only.
    do_cycle(0, 1, 11'h004, 0, 0, 3'b000, 11'h000, 32'h0, g, obs);
    check("fetch_if_rdata_word", if_rdata, 32'h0000_2083);
    do_cycle(0, 0, 11'h000, 0, 0, 3'b000, 11'h000, 32'h0, g, obs);

    // Conflict with both requests held: DATA, DATA, FETCH repeating.
    conflict_want = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 6; i++) begin
      do_cycle(0, 1, 11'h020 + 11'(i * 4), 1, 0, 3'b010, 11'h100 + 11'(i * 4), 32'h0, g, obs);
      check("conflict_grant_order", 32'(obs), 32'(conflict_want[i]));
    end
    do_cycle(0, 0, 11'h000, 0, 0, 3'b000, 11'h000, 32'h0, g, obs);

    // Store word then load it back on the next cycle.
    do_cycle(0, 0, 11'h000, 1, 1, 3'b010, 11'h00C, 32'h0000_002A, g, obs);
    do_cycle(0, 0, 11'h000, 1, 0, 3'b010, 11'h00C, 32'h0, g, obs);
    check("store_load_d_rdata", d_rdata, 32'h0000_002A);
    do_cycle(0, 0, 11'h000, 0, 0, 3'b000, 11'h000, 32'h0, g, obs);

    // Sign-extended byte load.
    do_cycle(0, 0, 11'h000, 1, 0, 3'b000, 11'h000, 32'h0, g, obs);
    check("lb_d_rdata", d_rdata, 32'hFFFF_FFF3);
    do_cycle(0, 0, 11'h000, 0, 0, 3'b000, 11'h000, 32'h0, g, obs);
    check("lb_d_rdata_hold", d_rdata, 32'hFFFF_FFF3);

    // Fetch gap clears the streak: fetch waits two more data grants.
    gap_if   = '{1, 0, 1, 1, 1};
    gap_want = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, gap_if[i], 11'h040, 1, 0, 3'b010, 11'h200 + 11'(i * 4), 32'h0, g, obs);
      check("gap_grant_order", 32'(obs), 32'(gap_want[i]));
    end
    do_cycle(0, 0, 11'h000, 0, 0, 3'b000, 11'h000, 32'h0, g, obs);

    // Randomized traffic with requesters holding until granted.
    begin
      bit            ip, dp, dwe, r;
      logic [AW-1:0] ia, da;
      logic [2:0]    df;
      logic [31:0]   dwd;
      ip = 0; dp = 0; dwe = 0; ia = '0; da = '0; df = '0; dwd = '0;
      for (int n = 0; n < 3000; n++) begin
        if (!ip && $urandom_range(0, 3) != 0) begin
          ip = 1;
          ia = 11'($urandom) & 11'h7FC;
        end
        if (!dp && $urandom_range(0, 2) != 0) begin
          dp  = 1;
          dwe = ($urandom_range(0, 2) == 0);
          df  = dwe ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
          da  = 11'($urandom);
          if (df[1:0] == 2'b01)      da[0]   = 1'b0;
          else if (df[1:0] != 2'b00) da[1:0] = 2'b00;
          dwd = $urandom;
        end
        r = ($urandom_range(0, 99) == 0);
        do_cycle(r, ip, ia, dp, dwe, df, da, dwd, g, obs);
        if (g == 1) ip = 0;
        if (g == 2) dp = 0;
      end
    end

    for (int i = 0; i < 4; i++)
      do_cycle(0, 0, 11'h000, 0, 0, 3'b000, 11'h000, 32'h0, g, obs);
    check("if_queue_drained", 32'(if_q.size()), 32'h0);
    check("d_queue_drained", 32'(d_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
